// File: rtl/csi2tx_p2b_seq_ctrl.sv
// Pixel-to-byte sequencer: latches the line DT, drives one-hot converter enables,
// the wrapping pixel counter, the one-pixel delay line and the end-of-line flush pulse.
// Optional per-line pixel statistics are built when CSI2TX_P2B_LINE_STATS_EN is defined.
module csi2tx_p2b_seq_ctrl #(
    parameter int PIXEL_W    = 14,
    parameter int LINE_CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               line_start,
    input  logic [5:0]         data_type,
    input  logic [PIXEL_W-1:0] pixel_data,
    input  logic               pixel_data_vld,
    output logic [4:0]         pixel_cnt,
    output logic [PIXEL_W-1:0] pixel_data_d1,
    output logic               sensor_pixel_vld_falling_edge,
    output logic [5:0]         conv_en,
    output logic               err_unsupported_dt,
    output logic               err_protocol
`ifdef CSI2TX_P2B_LINE_STATS_EN
    ,
    output logic [LINE_CNT_W-1:0] line_pixel_total,
    output logic                  line_stats_vld
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE, S_FLUSH} state_t;

    state_t     state;
    logic [5:0] dt_q;

    if (PIXEL_W < 1 || LINE_CNT_W < 1) begin : g_param_chk
        $error("csi2tx_p2b_seq_ctrl: PIXEL_W and LINE_CNT_W must be positive");
    end

    function automatic logic [5:0] dt_onehot(input logic [5:0] dt);
        case (dt)
            6'h28:   return 6'b000001;
            6'h29:   return 6'b000010;
            6'h2A:   return 6'b000100;
            6'h2B:   return 6'b001000;
            6'h2C:   return 6'b010000;
            6'h2D:   return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    // Last pixel index of one packing period for each format.
    function automatic logic [4:0] dt_wrap(input logic [5:0] dt);
        case (dt)
            6'h28:   return 5'd15;
            6'h29:   return 5'd31;
            6'h2A:   return 5'd3;
            6'h2B:   return 5'd15;
            6'h2C:   return 5'd7;
            6'h2D:   return 5'd15;
            default: return 5'd0;
        endcase
    endfunction

`ifdef CSI2TX_P2B_LINE_STATS_EN
    logic [LINE_CNT_W-1:0] stat_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                         <= S_IDLE;
            dt_q                          <= '0;
            pixel_cnt                     <= '0;
            pixel_data_d1                 <= '0;
            sensor_pixel_vld_falling_edge <= 1'b0;
            conv_en                       <= '0;
            err_unsupported_dt            <= 1'b0;
            err_protocol                  <= 1'b0;
`ifdef CSI2TX_P2B_LINE_STATS_EN
            stat_cnt                      <= '0;
            line_pixel_total              <= '0;
            line_stats_vld                <= 1'b0;
`endif
        end else begin
            sensor_pixel_vld_falling_edge <= 1'b0;
            err_unsupported_dt            <= 1'b0;
            err_protocol                  <= 1'b0;
`ifdef CSI2TX_P2B_LINE_STATS_EN
            line_stats_vld                <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (line_start) begin
                        if (dt_onehot(data_type) != 6'b0) begin
                            dt_q    <= data_type;
                            conv_en <= dt_onehot(data_type);
                            state   <= S_ARMED;
`ifdef CSI2TX_P2B_LINE_STATS_EN
                            stat_cnt <= '0;
`endif
                        end else begin
                            err_unsupported_dt <= 1'b1;
                            conv_en            <= '0;
                        end
                    end
                    // A pixel with no open line is dropped, even alongside line_start.
                    if (pixel_data_vld)
                        err_protocol <= 1'b1;
                end
                S_ARMED, S_ACTIVE: begin
                    if (line_start)
                        err_protocol <= 1'b1;
                    if (pixel_data_vld) begin
                        pixel_cnt     <= (pixel_cnt == dt_wrap(dt_q)) ? 5'd0 : pixel_cnt + 5'd1;
                        pixel_data_d1 <= pixel_data;
                        state         <= S_ACTIVE;
`ifdef CSI2TX_P2B_LINE_STATS_EN
                        if (stat_cnt != '1)
                            stat_cnt <= stat_cnt + LINE_CNT_W'(1);
`endif
                    end else if (state == S_ACTIVE) begin
                        // Any gap ends the line; pixel_cnt holds so converters see the fill level.
                        sensor_pixel_vld_falling_edge <= 1'b1;
                        state                         <= S_FLUSH;
`ifdef CSI2TX_P2B_LINE_STATS_EN
                        line_pixel_total <= stat_cnt;
                        line_stats_vld   <= 1'b1;
`endif
                    end
                end
                S_FLUSH: begin
                    if (line_start || pixel_data_vld)
                        err_protocol <= 1'b1;
                    pixel_cnt     <= '0;
                    pixel_data_d1 <= '0;
                    conv_en       <= '0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csi2tx_p2b_seq_ctrl.sv
// Self-checking bench for csi2tx_p2b_seq_ctrl: table of whole-line vectors, hand-written
// corner sequences, and random lines checked against a modulo-based line model.
module tb_csi2tx_p2b_seq_ctrl;
    localparam int PIXEL_W    = 14;
    localparam int LINE_CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               line_start = 1'b0;
    logic [5:0]         data_type = '0;
    logic [PIXEL_W-1:0] pixel_data = '0;
    logic               pixel_data_vld = 1'b0;
    logic [4:0]         pixel_cnt;
    logic [PIXEL_W-1:0] pixel_data_d1;
    logic               falling;
    logic [5:0]         conv_en;
    logic               err_unsupported_dt;
    logic               err_protocol;
`ifdef CSI2TX_P2B_LINE_STATS_EN
    logic [LINE_CNT_W-1:0] line_pixel_total;
    logic                  line_stats_vld;
`endif

    csi2tx_p2b_seq_ctrl #(.PIXEL_W(PIXEL_W), .LINE_CNT_W(LINE_CNT_W)) dut (
        .clk                           (clk),
        .rst_n                         (rst_n),
        .line_start                    (line_start),
        .data_type                     (data_type),
        .pixel_data                    (pixel_data),
        .pixel_data_vld                (pixel_data_vld),
        .pixel_cnt                     (pixel_cnt),
        .pixel_data_d1                 (pixel_data_d1),
        .sensor_pixel_vld_falling_edge (falling),
        .conv_en                       (conv_en),
        .err_unsupported_dt            (err_unsupported_dt),
        .err_protocol                  (err_protocol)
`ifdef CSI2TX_P2B_LINE_STATS_EN
        ,
        .line_pixel_total              (line_pixel_total),
        .line_stats_vld                (line_stats_vld)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Pixels per packing period, indexed by DT - 0x28.
    int per_tab[6] = '{16, 32, 4, 16, 8, 16};

    typedef struct {
        logic [5:0] dt;
        int         npix;
        logic [5:0] exp_conv;
        int         exp_flush_cnt;
    } vec_t;

    vec_t tab[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete line; all expectations come from pixel index arithmetic.
    task automatic run_line(input logic [5:0] dt, input int n, input int arm_gap,
                            input logic [5:0] exp_conv, input int exp_flush,
                            input bit vld_in_flush);
        int p;
        logic [PIXEL_W-1:0] prev;
        logic [PIXEL_W-1:0] cur;
        p    = per_tab[int'(dt) - 'h28];
        prev = '0;
        line_start = 1'b1; data_type = dt; pixel_data_vld = 1'b0;
        tick();
        line_start = 1'b0; data_type = 6'($urandom);
        chk("armed_conv_en", 32'(conv_en), 32'(exp_conv));
        chk("armed_errs", {err_unsupported_dt, err_protocol}, 0);
        repeat (arm_gap) tick();
        for (int k = 0; k < n; k++) begin
            cur = PIXEL_W'($urandom);
            pixel_data = cur; pixel_data_vld = 1'b1;
            chk("pix_cnt", 32'(pixel_cnt), 32'(k % p));
            chk("pix_d1", 32'(pixel_data_d1), 32'(prev));
            if (k > 0) chk("pix_quiet", {falling, err_protocol}, 0);
            tick();
            prev = cur;
        end
        pixel_data_vld = 1'b0; pixel_data = PIXEL_W'($urandom);
        tick();
        chk("flush_pulse", 32'(falling), 1);
        chk("flush_cnt", 32'(pixel_cnt), 32'(exp_flush));
        chk("flush_conv_en", 32'(conv_en), 32'(exp_conv));
        chk("flush_d1", 32'(pixel_data_d1), 32'(prev));
`ifdef CSI2TX_P2B_LINE_STATS_EN
        chk("stats_total", 32'(line_pixel_total), 32'(n));
        chk("stats_vld", 32'(line_stats_vld), 1);
`endif
        pixel_data_vld = vld_in_flush;
        tick();
        pixel_data_vld = 1'b0;
        chk("idle_after", {falling, conv_en, pixel_cnt, pixel_data_d1}, 0);
        chk("idle_err_protocol", 32'(err_protocol), 32'(vld_in_flush));
`ifdef CSI2TX_P2B_LINE_STATS_EN
        chk("stats_hold", {line_stats_vld, line_pixel_total}, 32'(n));
`endif
    endtask

    initial begin
        logic [5:0] dt;
        int n;

        tab[0] = '{6'h29, 32, 6'b000010, 0};
        tab[1] = '{6'h29, 5,  6'b000010, 5};
        tab[2] = '{6'h2A, 10, 6'b000100, 2};
        tab[3] = '{6'h28, 17, 6'b000001, 1};
        tab[4] = '{6'h2B, 16, 6'b001000, 0};
        tab[5] = '{6'h2C, 9,  6'b010000, 1};
        tab[6] = '{6'h2D, 3,  6'b100000, 3};
        tab[7] = '{6'h2A, 4,  6'b000100, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {falling, conv_en, pixel_cnt, pixel_data_d1, err_unsupported_dt, err_protocol}, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("post_reset_outputs", {falling, conv_en, pixel_cnt, pixel_data_d1, err_unsupported_dt, err_protocol}, 0);

        foreach (tab[i])
            run_line(tab[i].dt, tab[i].npix, i % 3, tab[i].exp_conv, tab[i].exp_flush_cnt, 1'b0);

        // Unsupported DT, then a stray pixel in IDLE
        line_start = 1'b1; data_type = 6'h12;
        tick();
        line_start = 1'b0;
        chk("unsup_pulse", 32'(err_unsupported_dt), 1);
        chk("unsup_conv_en", 32'(conv_en), 0);
        pixel_data_vld = 1'b1; pixel_data = 14'h123;
        tick();
        pixel_data_vld = 1'b0;
        chk("unsup_pulse_end", 32'(err_unsupported_dt), 0);
        chk("idle_vld_err", 32'(err_protocol), 1);
        chk("idle_vld_ignored", {pixel_cnt, pixel_data_d1}, 0);
        tick();
        chk("idle_err_end", 32'(err_protocol), 0);

        // line_start arriving mid-line alongside pixel 3
        line_start = 1'b1; data_type = 6'h2C;
        tick();
        for (int k = 0; k < 6; k++) begin
            pixel_data_vld = 1'b1; pixel_data = PIXEL_W'(k + 1);
            line_start = (k == 3); data_type = 6'h28;
            chk("midls_cnt", 32'(pixel_cnt), 32'(k));
            tick();
            if (k == 3) begin
                chk("midls_err", 32'(err_protocol), 1);
                chk("midls_conv_en", 32'(conv_en), 32'(6'b010000));
            end
        end
        line_start = 1'b0; pixel_data_vld = 1'b0;
        tick();
        chk("midls_flush_pulse", 32'(falling), 1);
        chk("midls_flush_cnt", 32'(pixel_cnt), 6);
        tick();

        // line_start and vld together in IDLE: line accepted, pixel dropped
        line_start = 1'b1; data_type = 6'h2A; pixel_data_vld = 1'b1; pixel_data = 14'h155;
        tick();
        line_start = 1'b0;
        chk("same_cycle_conv_en", 32'(conv_en), 32'(6'b000100));
        chk("same_cycle_err", 32'(err_protocol), 1);
        chk("same_cycle_dropped", {pixel_cnt, pixel_data_d1}, 0);
        pixel_data = 14'h0AA;
        tick();
        chk("same_cycle_first", {pixel_cnt, pixel_data_d1}, {5'd1, 14'h0AA});
        pixel_data_vld = 1'b0;
        tick();
        chk("same_cycle_flush_cnt", 32'(pixel_cnt), 1);
        tick();

        // Async reset mid-line
        line_start = 1'b1; data_type = 6'h2B;
        tick();
        line_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            pixel_data_vld = 1'b1; pixel_data = PIXEL_W'($urandom);
            tick();
        end
        chk("pre_reset_cnt", 32'(pixel_cnt), 7);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {falling, conv_en, pixel_cnt, pixel_data_d1, err_unsupported_dt, err_protocol}, 0);
`ifdef CSI2TX_P2B_LINE_STATS_EN
        chk("async_reset_stats", {line_stats_vld, line_pixel_total}, 0);
`endif
        pixel_data_vld = 1'b0;
        tick();
        chk("reset_no_flush", 32'(falling), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("reset_release_quiet", 32'(falling), 0);
        run_line(6'h2B, 4, 0, 6'b001000, 4, 1'b0);

        // Random lines against the modulo model
        for (int l = 0; l < 40; l++) begin
            if ($urandom_range(0, 7) == 0) begin
                dt = 6'($urandom);
                if (dt >= 6'h28 && dt <= 6'h2D) dt = dt ^ 6'h10;
                line_start = 1'b1; data_type = dt;
                tick();
                line_start = 1'b0;
                chk("rnd_unsup_pulse", 32'(err_unsupported_dt), 1);
                chk("rnd_unsup_conv_en", 32'(conv_en), 0);
                tick();
            end else begin
                dt = 6'h28 + 6'($urandom_range(0, 5));
                n  = $urandom_range(1, 70);
                run_line(dt, n, $urandom_range(0, 2), 6'(1 << (int'(dt) - 'h28)),
                         n % per_tab[int'(dt) - 'h28], $urandom_range(0, 3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/csi2tx_p2b_seq_ctrl.md
Name: csi2tx_p2b_seq_ctrl

Overview:
- Sequencer/controller for the pixel-to-byte (p2b) converter bank of the CSI-2 TX datapath.
- Latches the line's data type at line start and decodes it into one-hot conversion enables (RAW6..RAW14).
- Runs the shared pixel counter with per-format wrap, delays pixel data by one pixel, and generates the end-of-line flush pulse that makes converters emit partial DWs.
- Sits between the sensor pixel interface and the per-format p2b converters.

Parameters:
PIXEL_W, 14, width of pixel_data / pixel_data_d1 (widest supported format)
LINE_CNT_W, 16, width of the optional per-line pixel total counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
line_start  input  1  one-cycle pulse; latches data_type and arms the sequencer
data_type  input  6  CSI-2 DT code, sampled only on an accepted line_start
pixel_data  input  PIXEL_W  sensor pixel, LSB-aligned
pixel_data_vld  input  1  pixel valid; one pixel per cycle while high
pixel_cnt  output  5  position of the current pixel within the format packing period
pixel_data_d1  output  PIXEL_W  previous accepted pixel
sensor_pixel_vld_falling_edge  output  1  one-cycle end-of-line flush pulse
conv_en  output  6  one-hot: [0]RAW6 [1]RAW7 [2]RAW8 [3]RAW10 [4]RAW12 [5]RAW14
err_unsupported_dt  output  1  one-cycle pulse: line_start carried an unknown DT
err_protocol  output  1  one-cycle pulse: vld in IDLE, or line_start while ARMED/ACTIVE

Behaviour:
- Reset values: all outputs 0; state IDLE; latched DT 0.
- States: IDLE, ARMED, ACTIVE, FLUSH.

IDLE:
- line_start with a supported DT: latch DT, drive the conv_en one-hot (registered, valid the cycle after line_start), go to ARMED.
- line_start with an unsupported DT: err_unsupported_dt=1 for one cycle, conv_en=0, stay IDLE.
- pixel_data_vld=1: err_protocol pulse; pixel ignored (pixel_cnt and d1 unchanged).

ARMED:
- First pixel_data_vld=1 goes to ACTIVE; that pixel is counted.

ACTIVE:
- Each vld cycle: pixel_cnt <= (pixel_cnt==WRAP) ? 0 : pixel_cnt+1; pixel_data_d1 <= pixel_data.
- pixel_cnt presented to converters is the index of the pixel currently on pixel_data (0 for the first pixel).
- Both counter and d1 are registered and update on the edge that consumes the pixel.
- vld=0 goes to FLUSH; pixel_cnt holds.

FLUSH (exactly 1 cycle):
- sensor_pixel_vld_falling_edge=1; pixel_cnt still holds its last value (next unfilled index) so converters can test pixel_cnt!=0.
- Next edge: IDLE, pixel_cnt=0, conv_en=0, pixel_data_d1=0.

WRAP per DT:
- RAW6 0x28: 15
- RAW7 0x29: 31
- RAW8 0x2A: 3
- RAW10 0x2B: 15
- RAW12 0x2C: 7
- RAW14 0x2D: 15
- Any other DT is unsupported.

Boundaries and error handling:
- line_start in ARMED/ACTIVE/FLUSH: err_protocol pulse, ignored; latched DT unchanged.
- vld in FLUSH: treated as a new-line protocol error; err_protocol pulse, pixel dropped.
- A vld gap mid-line ends the line (no stall support).
- line_start and vld in the same cycle in IDLE: line_start is accepted, vld is flagged as err_protocol, pixel dropped.
- Counter wrap at exactly WRAP followed by the line end: pixel_cnt=0 during FLUSH, so converters emit no partial DW.
- Async reset mid-line: everything returns to reset values immediately; no flush pulse is generated.

Optional Feature:
- Macro: CSI2TX_P2B_LINE_STATS_EN.
- Enabled: adds output line_pixel_total [LINE_CNT_W-1:0] and line_stats_vld (1 bit).
  - An internal counter clears on an accepted line_start and increments per accepted pixel, saturating at all-ones.
  - In the FLUSH cycle, line_pixel_total is loaded with the final count and line_stats_vld pulses for 1 cycle.
  - line_pixel_total holds until the next FLUSH; reset value 0.
- Disabled: ports and counter absent; all other behaviour identical.

Test Plan:
1. line_start DT=0x29, then 32 consecutive vld pixels 0x01..0x20.
   - conv_en=6'b000010.
   - pixel_cnt runs 0..31; pixel_data_d1 lags one pixel.
   - In FLUSH: falling_edge=1 and pixel_cnt=0.
2. DT=0x29, 5 pixels.
   - In FLUSH: falling_edge=1 and pixel_cnt=5.
   - Then IDLE, pixel_cnt=0, conv_en=0.
3. DT=0x2A, 10 pixels.
   - pixel_cnt sequence 0,1,2,3,0,1,2,3,0,1; FLUSH pixel_cnt=2.
   - Optional feature: line_pixel_total=10 with line_stats_vld pulse.
4. line_start DT=0x12 → err_unsupported_dt pulse, conv_en=0, state IDLE.
   - Subsequent vld gives an err_protocol pulse and pixel_cnt stays 0.
5. DT=0x2C, 6 pixels, line_start asserted at pixel 3.
   - err_protocol pulse; counting continues to 5; FLUSH pixel_cnt=6.
6. DT=0x2B, assert rst_n=0 after 7 pixels.
   - All outputs 0 immediately; no falling_edge pulse.
   - After release, a new line starts with pixel_cnt=0.
